// File: rtl/accum_alu.sv
// Handshaked accumulator ALU: single-cycle add/sub/acc/load/read plus a WIDTH-step
// shift-add multiplier, with optional unsigned saturation and registered status flags.
module accum_alu #(
  parameter int unsigned WIDTH = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAcc  = 3'b010;
  localparam logic [2:0] OpClr  = 3'b011;
  localparam logic [2:0] OpMul  = 3'b100;
  localparam logic [2:0] OpLoad = 3'b101;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 overflow_q, overflow_d;

  logic                 accept, consume, mul_last, mul_hi;
  logic [WIDTH:0]       sum_ab, diff_ab, sum_acc;
  logic [WIDTH-1:0]     op_res, acc_new, mul_res;
  logic                 op_c, op_v;
  logic [2*WIDTH-1:0]   prod_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && op == OpMul) state_d = StMul;
      StMul:   if (ena && mul_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = ena && (state_q == StIdle) && (!out_valid_q || out_ready);
    out_valid = out_valid_q;
    result    = result_q;
    carry     = carry_q;
    overflow  = overflow_q;
    zero      = (result_q == '0);
  end

  assign accept  = in_valid && in_ready;
  assign consume = ena && out_valid_q && out_ready;

  // Single-cycle result; carry/overflow always come from the unsaturated value.
  always_comb begin
    sum_ab  = {1'b0, a} + {1'b0, b};
    diff_ab = {1'b0, a} - {1'b0, b};
    sum_acc = {1'b0, acc_q} + {1'b0, a};
    op_res  = acc_q;
    op_c    = 1'b0;
    op_v    = 1'b0;
    acc_new = acc_q;
    case (op)
      OpAdd: begin
        op_res = sum_ab[WIDTH-1:0];
        op_c   = sum_ab[WIDTH];
        op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
        if (SAT && op_c) op_res = '1;
      end
      OpSub: begin
        op_res = diff_ab[WIDTH-1:0];
        op_c   = diff_ab[WIDTH];
        op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
        if (SAT && op_c) op_res = '0;
      end
      OpAcc: begin
        op_res  = sum_acc[WIDTH-1:0];
        op_c    = sum_acc[WIDTH];
        op_v    = (acc_q[WIDTH-1] == a[WIDTH-1]) && (sum_acc[WIDTH-1] != acc_q[WIDTH-1]);
        if (SAT && op_c) op_res = '1;
        acc_new = op_res;
      end
      OpClr: begin
        op_res  = '0;
        acc_new = '0;
      end
      OpLoad: begin
        op_res  = a;
        acc_new = a;
      end
      default: op_res = acc_q;
    endcase
  end

  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_hi    = |prod_step[2*WIDTH-1:WIDTH];
    mul_res   = (SAT && mul_hi) ? '1 : prod_step[WIDTH-1:0];
    mul_last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    acc_d       = acc_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    if (consume) out_valid_d = 1'b0;
    if (state_q == StIdle) begin
      if (accept) begin
        if (op == OpMul) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          prod_d   = '0;
          cnt_d    = '0;
        end else begin
          acc_d       = acc_new;
          result_d    = op_res;
          carry_d     = op_c;
          overflow_d  = op_v;
          out_valid_d = 1'b1;
        end
      end
    end else if (ena) begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (mul_last) begin
        cnt_d       = '0;
        result_d    = mul_res;
        carry_d     = mul_hi;
        overflow_d  = mul_hi;
        out_valid_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Directed bench for accum_alu: one SAT=0 and one SAT=1 instance fed the same stimulus.
module tb_accum_alu;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAcc  = 3'b010;
  localparam logic [2:0] OpClr  = 3'b011;
  localparam logic [2:0] OpMul  = 3'b100;
  localparam logic [2:0] OpLoad = 3'b101;
  localparam logic [2:0] OpRead = 3'b110;

  logic       clk, rst_n, ena, in_valid, out_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       in_ready, out_valid, carry, overflow, zero;
  logic [7:0] result;
  logic       s_in_ready, s_out_valid, s_carry, s_overflow, s_zero;
  logic [7:0] s_result;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat;

  accum_alu #(.WIDTH(8), .SAT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  accum_alu #(.WIDTH(8), .SAT(1'b1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .carry(s_carry), .overflow(s_overflow), .zero(s_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns #1 after that edge.
  task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = OpAdd; a = '0; b = '0;
    #3;
    check("rst_result", result, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 1);
    #9 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    drive(OpAdd, 8'd200, 8'd100);
    check("add_carry_res", result, 44);
    check("add_carry_c", carry, 1);
    check("add_carry_v", overflow, 0);
    check("add_carry_valid", out_valid, 1);
    check("add_sat_res", s_result, 255);
    check("add_sat_c", s_carry, 1);

    drive(OpAdd, 8'd100, 8'd100);
    check("add_ovf_res", result, 200);
    check("add_ovf_c", carry, 0);
    check("add_ovf_v", overflow, 1);

    drive(OpSub, 8'd5, 8'd10);
    check("sub_res", result, 251);
    check("sub_borrow", carry, 1);
    check("sub_v", overflow, 0);
    check("sub_sat_res", s_result, 0);
    check("sub_sat_c", s_carry, 1);
    check("sub_sat_zero", s_zero, 1);

    drive(OpLoad, 8'd10, 8'd0);
    check("load_res", result, 10);
    drive(OpAcc, 8'd20, 8'd0);
    check("acc1_res", result, 30);
    check("acc1_c", carry, 0);
    drive(OpAcc, 8'd250, 8'd0);
    check("acc2_res", result, 24);
    check("acc2_c", carry, 1);
    check("acc2_sat_res", s_result, 255);
    drive(OpRead, 8'd0, 8'd0);
    check("read_res", result, 24);
    check("read_c", carry, 0);
    drive(OpClr, 8'd0, 8'd0);
    check("clr_res", result, 0);
    drive(OpRead, 8'd0, 8'd0);
    check("read_clr_res", result, 0);
    check("read_clr_zero", zero, 1);

    drive(OpMul, 8'd15, 8'd17);
    check("mul_busy_ready", in_ready, 0);
    check("mul_busy_valid", out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) check("mul_mid_ready", in_ready, 0);
    end
    check("mul_latency", lat, 8);
    check("mul_res", result, 255);
    check("mul_c", carry, 0);

    drive(OpMul, 8'd16, 8'd16);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("mul_hi_latency", lat, 8);
    check("mul_hi_res", result, 0);
    check("mul_hi_c", carry, 1);
    check("mul_hi_v", overflow, 1);
    check("mul_hi_sat_res", s_result, 255);

    drive(OpAdd, 8'd1, 8'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", result, 3);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drive(OpAdd, 8'd4, 8'd4);
    check("bp_release_res", result, 8);
    check("bp_release_valid", out_valid, 1);

    ena = 1'b0;
    in_valid = 1'b1; op = OpAdd; a = 8'd9; b = 8'd9;
    #1 check("ena_low_ready", in_ready, 0);
    @(posedge clk); #1;
    check("ena_low_res", result, 8);
    check("ena_low_valid", out_valid, 1);
    in_valid = 1'b0;
    ena = 1'b1;
    @(posedge clk); #1;
    check("consume_valid", out_valid, 0);
    check("consume_res_hold", result, 8);

    drive(OpMul, 8'd3, 8'd5);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midmul_rst_res", result, 0);
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_zero", zero, 1);
    check("midmul_rst_c", carry, 0);
    rst_n = 1'b1;
    #1 check("midmul_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    drive(OpAdd, 8'd1, 8'd1);
    check("post_rst_add", result, 2);
    check("post_rst_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
